// File: rtl/gpu_ctrl_sequencer.sv
// rtl/gpu_ctrl_sequencer.sv - GPU control sequencer: opcode decode plus EXEC/MULDIV/WB sequencing FSM.
// Optional macro GPU_CTRL_ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP until reset.
module gpu_ctrl_sequencer #(
    parameter int OPCODE_W    = 5,
    parameter int ALUOP_W     = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                branch_cond,
    output logic                instr_ready,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                i_mode,
    output logic                r_mode,
    output logic                branch_mode,
    output logic                compare_mode,
    output logic                wb_en,
    output logic                hilo_we,
    output logic                pc_load,
    output logic                done,
    output logic                illegal
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MULDIV, S_WB, S_TRAP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [OPCODE_W-1:0] opc_q;
    logic                cond_q;

    function automatic int unsigned op_num(input logic [OPCODE_W-1:0] opc);
        return 32'(opc);
    endfunction

    function automatic logic [ALUOP_W-1:0] dec_alu(input logic [OPCODE_W-1:0] opc);
        int unsigned a;
        a = 0;
        case (op_num(opc))
            5, 6, 23, 24, 25: a = 1;
            7, 8:             a = 2;
            9, 10:            a = 3;
            11:               a = 4;
            12:               a = 5;
            13:               a = 6;
            18:               a = 7;
            19:               a = 8;
            20:               a = 9;
            21:               a = 10;
            22:               a = 11;
            default:          a = 0;
        endcase
        return ALUOP_W'(a);
    endfunction

    // {i_mode, r_mode, branch_mode, compare_mode}
    function automatic logic [3:0] dec_mode(input logic [OPCODE_W-1:0] opc);
        logic [3:0] m;
        m = 4'b0000;
        case (op_num(opc))
            2, 4:                                      m = 4'b1000;
            1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14,
            15, 16, 17, 18, 19, 20, 21, 22:            m = 4'b0100;
            23:                                        m = 4'b0101;
            24, 25:                                    m = 4'b0111;
            26, 27:                                    m = 4'b0010;
            default:                                   m = 4'b0000;
        endcase
        return m;
    endfunction

    // {wb_en, hilo_we, pc_load} for the WB cycle
    function automatic logic [2:0] wb_pulses(input logic [OPCODE_W-1:0] opc, input logic cond);
        logic [2:0] p;
        p = 3'b000;
        case (op_num(opc))
            1, 2, 3, 4, 5, 6, 11, 12, 13, 14, 15,
            18, 19, 20, 21, 22, 23:                    p = 3'b100;
            7, 8, 9, 10, 16, 17:                       p = 3'b010;
            24:                                        p = {2'b00, cond};
            25:                                        p = {2'b00, ~cond};
            26, 27:                                    p = 3'b001;
            default:                                   p = 3'b000;
        endcase
        return p;
    endfunction

    function automatic logic is_muldiv(input logic [OPCODE_W-1:0] opc);
        return (op_num(opc) >= 7) && (op_num(opc) <= 10);
    endfunction

`ifdef GPU_CTRL_ILLEGAL_TRAP_EN
    function automatic logic is_illegal(input logic [OPCODE_W-1:0] opc);
        return op_num(opc) >= 28;
    endfunction
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            opc_q        <= '0;
            cond_q       <= 1'b0;
            instr_ready  <= 1'b1;
            alu_op       <= '0;
            i_mode       <= 1'b0;
            r_mode       <= 1'b0;
            branch_mode  <= 1'b0;
            compare_mode <= 1'b0;
            wb_en        <= 1'b0;
            hilo_we      <= 1'b0;
            pc_load      <= 1'b0;
            done         <= 1'b0;
`ifdef GPU_CTRL_ILLEGAL_TRAP_EN
            illegal      <= 1'b0;
`endif
        end else begin
            wb_en   <= 1'b0;
            hilo_we <= 1'b0;
            pc_load <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        opc_q        <= opcode;
                        state        <= S_EXEC;
                        instr_ready  <= 1'b0;
                        alu_op       <= dec_alu(opcode);
                        {i_mode, r_mode, branch_mode, compare_mode} <= dec_mode(opcode);
                    end
                end
                S_EXEC: begin
                    cond_q <= branch_cond;
                    if (is_muldiv(opc_q)) begin
                        state <= S_MULDIV;
                        cnt   <= (op_num(opc_q) >= 9) ? CNT_W'(DIV_CYCLES - 1)
                                                      : CNT_W'(MULT_CYCLES - 1);
`ifdef GPU_CTRL_ILLEGAL_TRAP_EN
                    end else if (is_illegal(opc_q)) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
`endif
                    end else begin
                        state <= S_WB;
                        done  <= 1'b1;
                        {wb_en, hilo_we, pc_load} <= wb_pulses(opc_q, branch_cond);
                    end
                end
                S_MULDIV: begin
                    if (cnt == '0) begin
                        state <= S_WB;
                        done  <= 1'b1;
                        {wb_en, hilo_we, pc_load} <= wb_pulses(opc_q, cond_q);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WB: begin
                    state        <= S_IDLE;
                    instr_ready  <= 1'b1;
                    alu_op       <= '0;
                    i_mode       <= 1'b0;
                    r_mode       <= 1'b0;
                    branch_mode  <= 1'b0;
                    compare_mode <= 1'b0;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_ctrl_sequencer.sv
// tb/tb_gpu_ctrl_sequencer.sv - self-checking bench for gpu_ctrl_sequencer (vector table + random vs reference model).
module tb_gpu_ctrl_sequencer;
    localparam int MC = 4;
    localparam int DC = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [4:0] opcode;
    logic       branch_cond;
    logic       instr_ready;
    logic [3:0] alu_op;
    logic       i_mode, r_mode, branch_mode, compare_mode;
    logic       wb_en, hilo_we, pc_load, done, illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpu_ctrl_sequencer #(
        .OPCODE_W(5), .ALUOP_W(4), .MULT_CYCLES(MC), .DIV_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .branch_cond(branch_cond), .instr_ready(instr_ready), .alu_op(alu_op),
        .i_mode(i_mode), .r_mode(r_mode), .branch_mode(branch_mode),
        .compare_mode(compare_mode), .wb_en(wb_en), .hilo_we(hilo_we),
        .pc_load(pc_load), .done(done), .illegal(illegal)
    );

    // {ready, alu_op[3:0], i, r, br, cmp, wb, hilo, pc, done, illegal}
    logic [13:0] act;
    assign act = {instr_ready, alu_op, i_mode, r_mode, branch_mode, compare_mode,
                  wb_en, hilo_we, pc_load, done, illegal};

    typedef struct {
        int opc; bit cond; int alu;
        bit im, rm, br, cm, wb, hi, pc;
        int lat;
    } vec_t;

    function automatic vec_t mkv(int opc, bit cond, int alu, bit im, bit rm, bit br, bit cm,
                                 bit wb, bit hi, bit pc, int lat);
        vec_t v;
        v.opc = opc; v.cond = cond; v.alu = alu; v.im = im; v.rm = rm; v.br = br;
        v.cm = cm; v.wb = wb; v.hi = hi; v.pc = pc; v.lat = lat;
        return v;
    endfunction

    function automatic logic [13:0] mk(bit rdy, int alu, bit im, bit rm, bit br, bit cm,
                                       bit wb, bit hi, bit pc, bit dn, bit ill);
        return {rdy, 4'(alu), im, rm, br, cm, wb, hi, pc, dn, ill};
    endfunction

    // Reference model written straight from the opcode rules.
    function automatic vec_t model_vec(int o, bit c);
        vec_t v;
        v.opc = o; v.cond = c;
        v.im  = (o == 2) || (o == 4);
        v.rm  = (o >= 1) && (o <= 25) && !v.im;
        if (o inside {5, 6, 23, 24, 25})  v.alu = 1;
        else if (o inside {7, 8})         v.alu = 2;
        else if (o inside {9, 10})        v.alu = 3;
        else if (o inside {[11:13]})      v.alu = o - 7;
        else if (o inside {[18:22]})      v.alu = o - 11;
        else                              v.alu = 0;
        v.br  = o inside {[24:27]};
        v.cm  = o inside {[23:25]};
        v.wb  = o inside {[1:6], [11:15], [18:23]};
        v.hi  = o inside {[7:10], 16, 17};
        v.pc  = (o == 26) || (o == 27) || (o == 24 && c) || (o == 25 && !c);
        v.lat = (o inside {7, 8}) ? MC + 2 : (o inside {9, 10}) ? DC + 2 : 2;
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %b required %b", name, cyc, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (instr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (instr_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL %s ready timeout: got %b required 1", name, instr_ready);
        end
    endtask

    task automatic transfer(input int opc, input bit cond);
        instr_valid = 1'b1;
        opcode      = 5'(opc);
        branch_cond = cond;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [13:0] exp;
        wait_ready(name);
        transfer(v.opc, v.cond);
        for (int k = 1; k <= v.lat + 1; k++) begin
            @(negedge clk);
            if (k < v.lat)
                exp = mk(0, v.alu, v.im, v.rm, v.br, v.cm, 0, 0, 0, 0, 0);
            else if (k == v.lat)
                exp = mk(0, v.alu, v.im, v.rm, v.br, v.cm, v.wb, v.hi, v.pc, 1, 0);
            else
                exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            check(name, k, exp);
        end
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(mkv(1,  0, 0,  0, 1, 0, 0, 1, 0, 0, 2));   // ADD
        tbl.push_back(mkv(2,  0, 0,  1, 0, 0, 0, 1, 0, 0, 2));   // ADDI
        tbl.push_back(mkv(6,  1, 1,  0, 1, 0, 0, 1, 0, 0, 2));   // SUBU
        tbl.push_back(mkv(7,  0, 2,  0, 1, 0, 0, 0, 1, 0, 6));   // MULT
        tbl.push_back(mkv(9,  0, 3,  0, 1, 0, 0, 0, 1, 0, 18));  // DIV
        tbl.push_back(mkv(10, 1, 3,  0, 1, 0, 0, 0, 1, 0, 18));  // DIVU
        tbl.push_back(mkv(12, 0, 5,  0, 1, 0, 0, 1, 0, 0, 2));   // SRA
        tbl.push_back(mkv(15, 0, 0,  0, 1, 0, 0, 1, 0, 0, 2));   // MFLO
        tbl.push_back(mkv(16, 0, 0,  0, 1, 0, 0, 0, 1, 0, 2));   // MTHI
        tbl.push_back(mkv(21, 0, 10, 0, 1, 0, 0, 1, 0, 0, 2));   // NAND
        tbl.push_back(mkv(22, 1, 11, 0, 1, 0, 0, 1, 0, 0, 2));   // XOR
        tbl.push_back(mkv(23, 1, 1,  0, 1, 0, 1, 1, 0, 0, 2));   // CMP
        tbl.push_back(mkv(24, 1, 1,  0, 1, 1, 1, 0, 0, 1, 2));   // BEQ taken
        tbl.push_back(mkv(24, 0, 1,  0, 1, 1, 1, 0, 0, 0, 2));   // BEQ not taken
        tbl.push_back(mkv(25, 1, 1,  0, 1, 1, 1, 0, 0, 0, 2));   // BNE not taken
        tbl.push_back(mkv(25, 0, 1,  0, 1, 1, 1, 0, 0, 1, 2));   // BNE taken
        tbl.push_back(mkv(26, 0, 0,  0, 0, 1, 0, 0, 0, 1, 2));   // JR
        tbl.push_back(mkv(27, 1, 0,  0, 0, 1, 0, 0, 0, 1, 2));   // J
        tbl.push_back(mkv(0,  1, 0,  0, 0, 0, 0, 0, 0, 0, 2));   // NOP

        reset = 1'b1; instr_valid = 1'b0; opcode = '0; branch_cond = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d_op%0d", i, tbl[i].opc));

        // Reset during the third MULDIV cycle of MULT aborts with no pulses.
        wait_ready("mult_abort");
        transfer(7, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("mult_abort_pre", k, mk(0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        end
        reset = 1'b1;
        @(negedge clk);
        check("mult_abort_idle", 5, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            @(negedge clk);
            check("mult_abort_quiet", k, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        run_vec(mkv(2, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2), "addi_after_abort");

        // Randomized instructions against the reference model.
        for (int n = 0; n < 60; n++) begin
            int o;
            bit c;
`ifdef GPU_CTRL_ILLEGAL_TRAP_EN
            o = $urandom_range(0, 27);
`else
            o = $urandom_range(0, 31);
`endif
            c = 1'($urandom_range(0, 1));
            run_vec(model_vec(o, c), $sformatf("rand%0d_op%0d", n, o));
        end

`ifdef GPU_CTRL_ILLEGAL_TRAP_EN
        wait_ready("trap");
        transfer(30, 0);
        @(negedge clk);
        check("trap_exec", 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            check("trap_hold", k, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        reset = 1'b1;
        @(negedge clk);
        check("trap_reset", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        run_vec(tbl[0], "add_after_trap");
`else
        run_vec(mkv(30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), "illegal_as_nop");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
